// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants and helpers for the ACS array; ACS_NORM_EN selects normalised vs modulo metric compare.
package viterbi_pkg;
  localparam int K_DEF = 3;
  localparam int NS_DEF = 1 << (K_DEF - 1);
  localparam int PM_W_DEF = 7;
  localparam int W_MAX = 16;
  function automatic logic [1:0] branch_out(input logic [6:0] r, input logic [6:0] g0, input logic [6:0] g1);
    return {^(r & g0), ^(r & g1)};
  endfunction
  function automatic logic [1:0] ham2(input logic [1:0] a, input logic [1:0] b);
    return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
  endfunction
  function automatic logic pm_lt(input logic [W_MAX-1:0] a, input logic [W_MAX-1:0] b, input int w);
`ifdef ACS_NORM_EN
    return (a & ((W_MAX'(1) << w) - W_MAX'(1))) < (b & ((W_MAX'(1) << w) - W_MAX'(1)));
`else
    // wrapped metrics: sign of the w-bit difference orders them while the spread stays below half range
    return |(W_MAX'(a - b) & (W_MAX'(1) << (w - 1)));
`endif
  endfunction
endpackage

// File: rtl/acs_cell.sv
// acs_cell: combinational add-compare-select for one trellis state.
module acs_cell
  import viterbi_pkg::*;
#(
  parameter int PM_W = PM_W_DEF
) (
  input  logic [PM_W-1:0] pm_p0,
  input  logic [PM_W-1:0] pm_p1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec_bit
);
  logic [PM_W-1:0] c0, c1;
  always_comb begin
    c0 = pm_p0 + PM_W'(bm0);
    c1 = pm_p1 + PM_W'(bm1);
    dec_bit = pm_lt(W_MAX'(c1), W_MAX'(c0), PM_W);
    pm_new = dec_bit ? c1 : c0;
  end
endmodule

// File: rtl/acs_array.sv
// acs_array: registered rate-1/2 Viterbi ACS array over all states with frame start, stall and best-state search.
// ACS_NORM_EN defined: subtract the previous minimum before each step instead of letting metrics wrap.
module acs_array
  import viterbi_pkg::*;
#(
  parameter int         K    = K_DEF,
  parameter logic [6:0] G0   = 7'o7,
  parameter logic [6:0] G1   = 7'o5,
  parameter int         PM_W = PM_W_DEF,
  parameter int         INIT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           sof,
  input  logic [1:0]                     data_recv,
  output logic                           out_valid,
  output logic [(1<<(K-1))-1:0]          dec,
  output logic [(1<<(K-1))*PM_W-1:0]     pm_flat,
  output logic [K-2:0]                   best_state
);
  localparam int NS = 1 << (K - 1);
`ifdef ACS_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif
  logic [PM_W-1:0] pm_q [NS];
  logic [PM_W-1:0] pm_d [NS];
  logic [PM_W-1:0] base [NS];
  logic [PM_W-1:0] min_q, min_d;
  logic [NS-1:0]   dec_q, dec_d;
  logic [K-2:0]    best_q, best_d;
  logic            valid_q;
  always_comb begin
    for (int s = 0; s < NS; s++)
      base[s] = sof ? (s == 0 ? '0 : PM_W'(INIT)) : pm_q[s] - (NORM ? min_q : '0);
  end
  for (genvar n = 0; n < NS; n++) begin : g_state
    localparam int P0 = (2 * n) % NS;
    localparam int B = n / (NS / 2);
    localparam logic [6:0] R0 = 7'(B * NS + P0);
    acs_cell #(.PM_W(PM_W)) u_cell (
      .pm_p0  (base[P0]),
      .pm_p1  (base[P0+1]),
      .bm0    (ham2(branch_out(R0, G0, G1), data_recv)),
      .bm1    (ham2(branch_out(R0 + 7'd1, G0, G1), data_recv)),
      .pm_new (pm_d[n]),
      .dec_bit(dec_d[n])
    );
    assign pm_flat[n*PM_W +: PM_W] = pm_q[n];
  end
  always_comb begin
    min_d = pm_d[0];
    best_d = '0;
    for (int s = 1; s < NS; s++)
      if (pm_lt(W_MAX'(pm_d[s]), W_MAX'(min_d), PM_W)) begin
        min_d = pm_d[s];
        best_d = (K-1)'(s);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) pm_q[s] <= (s == 0) ? '0 : PM_W'(INIT);
      min_q <= '0;
      dec_q <= '0;
      best_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        pm_q <= pm_d;
        min_q <= min_d;
        dec_q <= dec_d;
        best_q <= best_d;
      end
    end
  end
  assign out_valid = valid_q;
  assign dec = dec_q;
  assign best_state = best_q;
endmodule

// File: tb/tb_acs_array.sv
// tb_acs_array: directed vector table plus a random-symbol run against an independent trellis model (K=3, G=7,5).
module tb_acs_array;
`ifdef ACS_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, sof = 1'b0;
  logic [1:0] data_recv = 2'b00;
  logic out_valid;
  logic [3:0] dec;
  logic [27:0] pm_flat;
  logic [1:0] best_state;
  int n_chk = 0, n_fail = 0;

  acs_array dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .data_recv(data_recv),
    .out_valid(out_valid), .dec(dec), .pm_flat(pm_flat), .best_state(best_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, vin, sof;
    logic [1:0] d;
    logic ev;
    logic [3:0] edec;
    logic [27:0] epm;
    logic [1:0] eb;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic r, v, s, input logic [1:0] d, input logic ev, input logic [3:0] edec,
                     input int p3, p2, p1, p0, input logic [1:0] eb);
    vec_t x;
    x.rst = r; x.vin = v; x.sof = s; x.d = d; x.ev = ev; x.edec = edec;
    x.epm = {7'(p3), 7'(p2), 7'(p1), 7'(p0)}; x.eb = eb;
    tv.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int tm[4], nm[4], exp_pm[4];
  logic [3:0] mdec;
  int mbest, off;

  task automatic model_step(input logic s, input logic [1:0] d);
    int prev[4], c0, c1, mn;
    logic [1:0] p;
    logic b, o0, o1;
    int bm[2];
    prev = s ? '{0, 16, 16, 16} : tm;
    off = 0;
    if (NORM && !s) begin
      off = tm[0];
      for (int i = 1; i < 4; i++) if (tm[i] < off) off = tm[i];
    end
    for (int n = 0; n < 4; n++) begin
      b = n[1];
      for (int j = 0; j < 2; j++) begin
        p = 2'((2 * n + j) % 4);
        o0 = b ^ p[1] ^ p[0];
        o1 = b ^ p[0];
        bm[j] = int'(o0 != d[1]) + int'(o1 != d[0]);
      end
      c0 = prev[(2 * n) % 4] + bm[0];
      c1 = prev[(2 * n) % 4 + 1] + bm[1];
      mdec[n] = c1 < c0;
      nm[n] = mdec[n] ? c1 : c0;
    end
    mn = nm[0]; mbest = 0;
    for (int i = 1; i < 4; i++) if (nm[i] < mn) begin mn = nm[i]; mbest = i; end
    for (int i = 0; i < 4; i++) exp_pm[i] = NORM ? nm[i] - off : nm[i] % 128;
    tm = nm;
  endtask

  initial begin
    add(1,0,0,2'b00, 0,4'h0, 16,16,16,0, 2'd0);
    add(0,1,1,2'b00, 1,4'h0, 17,2,17,0, 2'd0);
    for (int i = 0; i < 5; i++) add(0,0,0,2'b11, 0,4'h0, 17,2,17,0, 2'd0);
    add(0,1,1,2'b11, 1,4'h0, 17,0,17,2, 2'd2);
    add(0,1,0,2'b10, 1,4'h0, 2,3,0,3, 2'd1);
    add(0,1,0,2'b00, 1,4'hf, 3,0,3,2, 2'd2);
    add(0,1,0,2'b01, 1,4'h0, 0,3,2,3, 2'd3);
    add(0,1,1,2'b00, 1,4'h0, 17,2,17,0, 2'd0);
    add(1,1,0,2'b11, 0,4'h0, 16,16,16,0, 2'd0);
    add(0,0,0,2'b01, 0,4'h0, 16,16,16,0, 2'd0);
    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst; in_valid = tv[i].vin; sof = tv[i].sof; data_recv = tv[i].d;
      @(posedge clk); #1;
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(tv[i].ev));
      check($sformatf("v%0d.dec", i), 32'(dec), 32'(tv[i].edec));
      check($sformatf("v%0d.pm", i), 32'(pm_flat), 32'(tv[i].epm));
      check($sformatf("v%0d.best", i), 32'(best_state), 32'(tv[i].eb));
    end
    begin
      logic [1:0] st, e;
      logic u, v;
      logic [1:0] sym;
      st = 2'b00;
      for (int k = 0; k < 2000; k++) begin
        @(negedge clk);
        v = (k == 0) || ($urandom_range(9) != 0);
        u = 1'($urandom_range(1));
        e = {1'($urandom_range(9) == 0), 1'($urandom_range(9) == 0)};
        sym = {u ^ st[1] ^ st[0], u ^ st[0]} ^ e;
        in_valid = v; sof = (k == 0); data_recv = sym;
        if (v) begin
          model_step(k == 0, sym);
          st = {u, st[1]};
        end
        @(posedge clk); #1;
        check("rnd.out_valid", 32'(out_valid), 32'(v));
        if (v) begin
          check("rnd.dec", 32'(dec), 32'(mdec));
          check("rnd.best", 32'(best_state), 32'(mbest));
          for (int s = 0; s < 4; s++) begin
            check("rnd.pm", 32'(pm_flat[s*7 +: 7]), 32'(exp_pm[s]));
            if (NORM) check("rnd.pm_bound", 32'(pm_flat[s*7 +: 7] < 7'd64), 32'd1);
          end
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
